// File: rtl/mac_pkg.sv
// Shared types, defaults and width helpers for the MAC accumulator stage.
package mac_pkg;

    localparam int unsigned N_TERMS_DEF = 4;
    localparam int unsigned ACC_W_DEF   = 10;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned PROD_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Operand pair as handed to the multiplier.
    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

    // Ceiling log2; clog2(0) and clog2(1) both return 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Term counter width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n_terms);
        return (clog2(n_terms) < 1) ? 1 : clog2(n_terms);
    endfunction

endpackage

// File: rtl/mac_acc_reg.sv
// Accumulator register with adder, clear/load and sticky overflow flag.
// MAC_ACC_SAT_EN: saturate to all-ones on carry instead of wrapping.
module mac_acc_reg
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [PROD_W-1:0] add_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              ovf_o
);

    localparam int unsigned SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum_c;
    logic             carry_c;

    // Clear wins over load; the carry bit drives both overflow and saturation.
    always_comb begin
        sum_c   = {1'b0, acc_q} + SUM_W'(add_i);
        carry_c = sum_c[ACC_W];
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (load_i) begin
`ifdef MAC_ACC_SAT_EN
            acc_d = carry_c ? '1 : sum_c[ACC_W-1:0];
`else
            acc_d = sum_c[ACC_W-1:0];
`endif
            ovf_d = ovf_q | carry_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_accumulator.sv
// Issues operand pairs to the sequential multiplier and sums N_TERMS products.
// Optional MAC_ACC_SAT_EN (in mac_acc_reg) selects saturating accumulation.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS = N_TERMS_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a_in,
    input  logic [OP_W-1:0]   b_in,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_out,
    input  logic              mul_done,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              overflow
);

    localparam int unsigned     CNT_W = cnt_width(N_TERMS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TERMS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    operand_t         op_q, op_d;
    logic             done_q;
    logic             done_evt_c;
    logic             last_c;
    logic             acc_clr_c;
    logic             acc_load_c;

    // Only a rising edge of mul_done counts; a level already high is stale.
    assign done_evt_c = mul_done & ~done_q;
    assign last_c     = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)   state_d = ST_ISSUE;
            ST_ISSUE:                 state_d = ST_WAIT;
            ST_WAIT:  if (done_evt_c) state_d = ST_ACCUM;
            ST_ACCUM:                 state_d = last_c ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (acc_ready)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        mul_start  = 1'b0;
        acc_valid  = 1'b0;
        acc_load_c = 1'b0;
        acc_clr_c  = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready   = 1'b1;
            ST_ISSUE: mul_start  = 1'b1;
            ST_ACCUM: acc_load_c = 1'b1;
            ST_HOLD: begin
                acc_valid = 1'b1;
                acc_clr_c = acc_ready;
            end
            default: ;
        endcase
    end

    // Operand capture and term counter.
    always_comb begin
        op_d  = op_q;
        cnt_d = cnt_q;
        if ((state_q == ST_IDLE) && in_valid) begin
            op_d.a = a_in;
            op_d.b = b_in;
        end
        if (state_q == ST_ACCUM) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            done_q <= mul_done;
        end
    end

    assign mul_a = op_q.a;
    assign mul_b = op_q.b;

    mac_acc_reg #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (acc_clr_c),
        .load_i (acc_load_c),
        .add_i  (mul_out),
        .acc_o  (acc_out),
        .ovf_o  (overflow)
    );

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: three configurations (4x10b, 4x8b, 1x10b) each with a multiplier model.
`timescale 1ns/1ps
module tb_mac_accumulator;

    localparam int NI     = 3;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_a [NI];
    logic [3:0]  a_in_a     [NI];
    logic [3:0]  b_in_a     [NI];
    logic        acc_ready_a[NI];
    int unsigned stale_a    [NI];

    logic        in_ready_a [NI];
    logic        mul_start_a[NI];
    logic        acc_valid_a[NI];
    logic        ovf_a      [NI];
    logic [9:0]  acc_out_a  [NI];
    int unsigned nstart_a   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int unsigned dly(input int unsigned n);
        case (n % 8)
            0: return 3;
            1: return 8;
            2: return 5;
            3: return 4;
            4: return 7;
            5: return 6;
            6: return 3;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NT = (g == 2) ? 1 : 4;
        localparam int unsigned AW = (g == 1) ? 8 : 10;

        logic          ir, ms, av, ov, md, busy;
        logic [3:0]    ma, mb;
        logic [AW-1:0] ao;
        logic [7:0]    mo, prod;
        int unsigned   t, d, ns;

        mac_accumulator #(.N_TERMS(NT), .ACC_W(AW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (ir),
            .a_in      (a_in_a[g]),
            .b_in      (b_in_a[g]),
            .mul_start (ms),
            .mul_a     (ma),
            .mul_b     (mb),
            .mul_out   (mo),
            .mul_done  (md),
            .acc_out   (ao),
            .acc_valid (av),
            .acc_ready (acc_ready_a[g]),
            .overflow  (ov)
        );

        assign in_ready_a[g]  = ir;
        assign mul_start_a[g] = ms;
        assign acc_valid_a[g] = av;
        assign ovf_a[g]       = ov;
        assign acc_out_a[g]   = 10'(ao);
        assign nstart_a[g]    = ns;

        // Multiplier model: done is a level that stays high until the next start;
        // in stale mode it also stays high for stale_a cycles after start.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                md   <= (stale_a[g] != 0);
                mo   <= 8'hFF;
                prod <= 8'h00;
                t    <= 0;
                d    <= 3;
                ns   <= 0;
                busy <= 1'b0;
            end else if (ms) begin
                ns   <= ns + 1;
                busy <= 1'b1;
                t    <= 1;
                d    <= dly(ns);
                prod <= 8'(ma) * 8'(mb);
                mo   <= 8'hFF;
                md   <= (stale_a[g] != 0);
            end else if (busy) begin
                t <= t + 1;
                if (t == stale_a[g]) md <= 1'b0;
                if (t == stale_a[g] + d) begin
                    md   <= 1'b1;
                    mo   <= prod;
                    busy <= 1'b0;
                end
            end
        end
    end

    typedef struct {
        int unsigned inst;
        int unsigned nterms;
        logic [3:0]  a[4];
        logic [3:0]  b[4];
        int unsigned exp_acc;
        int unsigned exp_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int unsigned inst, input int unsigned n,
                           input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3,
                           input int unsigned ex, input int unsigned eo);
        vec_t v;
        v.inst = inst; v.nterms = n; v.exp_acc = ex; v.exp_ovf = eo;
        v.a[0] = 4'(a0); v.b[0] = 4'(b0); v.a[1] = 4'(a1); v.b[1] = 4'(b1);
        v.a[2] = 4'(a2); v.b[2] = 4'(b2); v.a[3] = 4'(a3); v.b[3] = 4'(b3);
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_pair(input int g, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_a[g] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_a[g]) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        in_valid_a[g] = 1'b1;
        a_in_a[g]     = a;
        b_in_a[g]     = b;
        @(negedge clk);
        in_valid_a[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g, output bit ok);
        int n;
        n = 0;
        while (!acc_valid_a[g] && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        ok = acc_valid_a[g];
        if (!ok) chk("acc_valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit          ok;
        int unsigned ns0;
        int          g;

        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid_a[i] = 1'b0; a_in_a[i] = '0; b_in_a[i] = '0;
            acc_ready_a[i] = 1'b1; stale_a[i] = 0;
        end

        add_vec(0, 4, 14, 11, 6, 12, 13, 13, 15, 15, 620, 0);
        add_vec(0, 4, 1, 2, 3, 4, 0, 9, 15, 1, 29, 0);
        add_vec(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MAC_ACC_SAT_EN
        add_vec(1, 4, 14, 11, 6, 12, 13, 13, 1, 1, 255, 1);
        add_vec(1, 4, 15, 15, 15, 15, 1, 1, 0, 0, 255, 1);
`else
        add_vec(1, 4, 14, 11, 6, 12, 13, 13, 1, 1, 140, 1);
        add_vec(1, 4, 15, 15, 15, 15, 1, 1, 0, 0, 195, 1);
`endif
        add_vec(1, 4, 15, 15, 3, 5, 5, 3, 0, 7, 255, 0);
        add_vec(2, 1, 6, 12, 0, 0, 0, 0, 0, 0, 72, 0);
        add_vec(2, 1, 15, 15, 0, 0, 0, 0, 0, 0, 225, 0);

        repeat (2) @(negedge clk);
        chk("rst_acc_out",   acc_out_a[0],   0);
        chk("rst_acc_valid", acc_valid_a[0], 0);
        chk("rst_in_ready",  in_ready_a[0],  1);
        chk("rst_overflow",  ovf_a[0],       0);
        chk("rst_mul_start", mul_start_a[0], 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vq[v]) begin
            g = int'(vq[v].inst);
            acc_ready_a[g] = 1'b1;
            ns0 = nstart_a[g];
            for (int k = 0; k < int'(vq[v].nterms); k++) send_pair(g, vq[v].a[k], vq[v].b[k]);
            wait_valid(g, ok);
            if (ok) begin
                chk($sformatf("vec%0d_acc_out", v),  acc_out_a[g], vq[v].exp_acc);
                chk($sformatf("vec%0d_overflow", v), ovf_a[g],     vq[v].exp_ovf);
                chk($sformatf("vec%0d_starts", v),   nstart_a[g] - ns0, vq[v].nterms);
                @(negedge clk);
                chk($sformatf("vec%0d_valid_1cyc", v), acc_valid_a[g], 0);
                chk($sformatf("vec%0d_acc_clear", v),  acc_out_a[g],   0);
            end
        end

        // Backpressure: result held for 5 cycles while in_valid is asserted.
        acc_ready_a[0] = 1'b0;
        ns0 = nstart_a[0];
        send_pair(0, 14, 11); send_pair(0, 6, 12); send_pair(0, 13, 13); send_pair(0, 15, 15);
        wait_valid(0, ok);
        if (ok) begin
            in_valid_a[0] = 1'b1; a_in_a[0] = 4'd1; b_in_a[0] = 4'd1;
            for (int c = 0; c < 5; c++) begin
                chk("bp_acc_valid", acc_valid_a[0], 1);
                chk("bp_acc_out",   acc_out_a[0],   620);
                chk("bp_in_ready",  in_ready_a[0],  0);
                @(negedge clk);
            end
            in_valid_a[0] = 1'b0;
            acc_ready_a[0] = 1'b1;
            @(negedge clk);
            chk("bp_released",  acc_valid_a[0], 0);
            chk("bp_acc_clear", acc_out_a[0],   0);
            chk("bp_starts",    nstart_a[0] - ns0, 4);
        end
        for (int k = 0; k < 4; k++) send_pair(0, 2, 3);
        wait_valid(0, ok);
        if (ok) chk("bp_next_sum", acc_out_a[0], 24);
        @(negedge clk);

        // Stale done: mul_done high from reset and for 2 cycles after start.
        stale_a[0] = 2;
        do_reset();
        send_pair(0, 14, 11);
        repeat (3) @(negedge clk);
        chk("stale_no_accum", acc_out_a[0], 0);
        send_pair(0, 6, 12); send_pair(0, 13, 13); send_pair(0, 15, 15);
        wait_valid(0, ok);
        if (ok) chk("stale_sum", acc_out_a[0], 620);
        @(negedge clk);
        stale_a[0] = 0;

        // Asynchronous reset while waiting on the third product.
        send_pair(0, 14, 11); send_pair(0, 6, 12); send_pair(0, 13, 13);
        repeat (2) @(negedge clk);
        chk("midwait_partial", acc_out_a[0], 226);
        #1 rst = 1'b0;
        #1;
        chk("midrst_acc_out",   acc_out_a[0],   0);
        chk("midrst_acc_valid", acc_valid_a[0], 0);
        chk("midrst_overflow",  ovf_a[0],       0);
        chk("midrst_in_ready",  in_ready_a[0],  1);
        @(negedge clk);
        rst = 1'b1;
        send_pair(0, 14, 11); send_pair(0, 6, 12); send_pair(0, 13, 13); send_pair(0, 15, 15);
        wait_valid(0, ok);
        if (ok) chk("after_rst_sum", acc_out_a[0], 620);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the sequential 4x4 multiplier in the MAC datapath.
- Accepts operand pairs from upstream and issues each pair to the multiplier with a start pulse, then waits for the multiplier's done.
- Adds each 8-bit product into a wide accumulator. After N_TERMS products it presents the sum to the consumer with a valid/ready handshake.

Parameters:
- N_TERMS, 4, products summed per result (>=1).
- ACC_W, 10, accumulator width (>=8); no overflow possible when ACC_W >= 8+clog2(N_TERMS).
- CNT_W, clog2(N_TERMS) (min 1), term counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  block can accept a pair.
- a_in  in  4  operand A.
- b_in  in  4  operand B.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  4  registered A to the multiplier.
- mul_b  out  4  registered B to the multiplier.
- mul_out  in  8  multiplier product.
- mul_done  in  1  multiplier done (level).
- acc_out  out  ACC_W  accumulated sum.
- acc_valid  out  1  acc_out is final.
- acc_ready  in  1  consumer accepts the result.
- overflow  out  1  sticky: the current sum exceeded 2^ACC_W-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; acc, count, mul_a, mul_b, overflow, done_q all cleared.
  - mul_start=0, acc_valid=0, in_ready=1 (IDLE decode).
  - Reset mid-operation abandons the partial sum. The multiplier shares the reset net at top level.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a_in/b_in into mul_a/mul_b, go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle, in_ready=0, go to WAIT.
- WAIT:
  - done_q is mul_done registered every cycle.
  - A completion event is mul_done=1 with done_q=0 (rising edge) while in WAIT.
  - A level-high mul_done already present on entry is ignored.
  - On the event, go to ACCUM. There is no timeout.
- ACCUM (one cycle):
  - acc <= acc + zero-extended mul_out (mod 2^ACC_W); a carry out sets overflow.
  - If count==N_TERMS-1, count clears and the next state is HOLD.
  - Otherwise count increments and the next state is IDLE.
- HOLD:
  - acc_valid=1; acc_out stable; in_ready=0.
  - When acc_ready=1 in the same cycle: acc and overflow clear, go to IDLE.
- Latency per term: 1 (capture) + 1 (ISSUE) + multiplier time + 1 (ACCUM) cycles.
- A new pair is never accepted while a term or result is pending (single outstanding operation).
- acc_out is driven from the acc register in all states. Consumers qualify it with acc_valid.
- in_valid with acc_valid=1 has no effect until the handshake completes.
- N_TERMS=1: every product goes directly to HOLD.

Optional Feature:
- Macro: MAC_ACC_SAT_EN.
- Defined: on carry out, acc saturates to 2^ACC_W-1 and overflow is set. Further adds keep acc saturated.
- Undefined: acc wraps mod 2^ACC_W and overflow is still set.

Decomposition:
- Shared package mac_pkg holds:
  - state encoding constants (IDLE, ISSUE, WAIT, ACCUM, HOLD; 3-bit);
  - default N_TERMS / ACC_W;
  - the clog2 helper.
- One natural sub-module: mac_acc_reg. It is the ACC_W adder plus register, with clear, load, overflow flag and the MAC_ACC_SAT_EN logic.
- The controller FSM and counter stay in the top module.

Test Plan:
- Basic sum, multiplier model with variable 3-8 cycle delay:
  - Stimulus: pairs (14,11), (6,12), (13,13), (15,15); acc_ready=1.
  - Response: acc_out=620, acc_valid for 1 cycle, overflow=0, exactly 4 mul_start pulses.
- Backpressure:
  - Stimulus: same stream; acc_ready=0 for 5 cycles after acc_valid rises.
  - Response: acc_valid and acc_out=620 held, in_ready=0 throughout; next sum starts from 0.
- Overflow, ACC_W=8, stimulus (14,11), (6,12), (13,13), (1,1):
  - Without MAC_ACC_SAT_EN: acc_out=140, overflow=1.
  - With MAC_ACC_SAT_EN: acc_out=255, overflow=1.
- Stale done:
  - Stimulus: model holds mul_done=1 from reset.
  - Response: no accumulation occurs until mul_done falls and rises again after mul_start.
- Reset mid-WAIT:
  - Stimulus: drive rst=0 asynchronously after 2 terms while waiting on the 3rd.
  - Response: immediately state IDLE, acc_out=0, acc_valid=0, overflow=0, in_ready=1. A fresh 4-term stream then yields the correct sum.
- N_TERMS=1:
  - Stimulus: pair (6,12).
  - Response: acc_out=72, acc_valid after one term.
